mem_access_unit: RTL

- Initiator side of the data-memory port: turns load/store requests from the execute stage into word-granular accesses on the 256-word synchronous data memory.
- The memory responder has no byte enables. Sub-word stores are therefore done as read-modify-write.
- Loads return byte, half or word data, sign- or zero-extended.
- Checks alignment and range, and flags errors without touching memory.

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-only synchronous data memory
// Sub-word stores are done as read-modify-write because the memory has no byte enables.
module mem_access_unit #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        req_error;
    logic [31:0] word_index;

    assign accept     = req_valid & req_ready;
    assign word_index = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};

    always_comb begin
        req_error = 1'b0;
        if (req_size == 2'b11)
            req_error = 1'b1;
        if (req_size == SIZE_HALF && req_addr[0])
            req_error = 1'b1;
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
            req_error = 1'b1;
        if (|req_addr[31:ADDR_W+2])
            req_error = 1'b1;
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: load_extract = {{24{sgn & b[7]}}, b};
            SIZE_HALF: load_extract = {{16{sgn & h[15]}}, h};
            default:   load_extract = word;
        endcase
    endfunction

    // Overwrite only the addressed lane; other lanes keep what memory returned.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [15:0] data
    );
        store_merge = word;
        if (size == SIZE_BYTE) begin
            case (lane)
                2'd0:    store_merge[7:0]   = data[7:0];
                2'd1:    store_merge[15:8]  = data[7:0];
                2'd2:    store_merge[23:16] = data[7:0];
                default: store_merge[31:24] = data[7:0];
            endcase
        end else begin
            if (lane[1])
                store_merge[31:16] = data;
            else
                store_merge[15:0]  = data;
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_error       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            write_q          <= 1'b0;
            size_q           <= '0;
            signed_q         <= 1'b0;
            lane_q           <= '0;
            wdata_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready  <= 1'b0;
                        write_q    <= req_write;
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        resp_rdata <= '0;
                        resp_error <= req_error;
                        if (req_error) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_address <= word_index;
                            if (req_write && req_size == SIZE_WORD) begin
                                mem_write_data   <= req_wdata;
                                mem_write_enable <= 1'b1;
                                state            <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (write_q) begin
                        mem_write_data   <= store_merge(mem_read_data, size_q, lane_q, wdata_q);
                        mem_write_enable <= 1'b1;
                        state            <= WR;
                    end else begin
                        resp_rdata <= load_extract(mem_read_data, size_q, lane_q, signed_q);
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    mem_write_enable <= 1'b0;
                    resp_valid       <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
